// File: rtl/pong_referee_pkg.sv
// Shared state and winner encodings for the pong match referee.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/pong_referee_if.sv
// Ball control/score link: the referee (master) drives animate/start/ball_reset,
// the ball (slave) returns its held score flags.
interface pong_referee_if;
  logic left_score;
  logic right_score;
  logic animate;
  logic start;
  logic ball_reset;

  modport master (input left_score, right_score, output animate, start, ball_reset);
  modport slave  (output left_score, right_score, input animate, start, ball_reset);
endinterface

// File: rtl/pong_referee_rise.sv
// Rising-edge detector with a configurable reset value for the history bit.
// Resetting the history high suppresses an edge from a level already high at reset.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);
  logic prev;

  // history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;
endmodule

// File: rtl/pong_referee.sv
// Match controller: serve delay, pause, point keeping and winner detection.
module pong_referee
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 120
) (
  input  logic           in_clock,
  input  logic           in_reset_n,
  input  logic           in_ani_stb,
  input  logic           in_btn_start,
  input  logic           in_btn_pause,
  pong_referee_if.master ball,
  output logic [3:0]     out_left_points,
  output logic [3:0]     out_right_points,
  output logic [1:0]     out_winner,
  output logic [2:0]     out_state
);
  localparam int NUM_DET = 4;
  // detector order: start, pause, left score, right score; buttons reset history high
  localparam logic [NUM_DET-1:0] DET_RST = 4'b0011;
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]    WIN_PTS  = 4'(WIN_SCORE);

  logic [NUM_DET-1:0] det_in, det_rise;
  logic start_rise, pause_rise, left_rise, right_rise;

  assign det_in = {ball.right_score, ball.left_score, in_btn_pause, in_btn_start};

  for (genvar g = 0; g < NUM_DET; g++) begin : g_det
    rise_detect #(.RESET_VAL(DET_RST[g])) u_det (
      .clk  (in_clock),
      .rst_n(in_reset_n),
      .sig  (det_in[g]),
      .rise (det_rise[g])
    );
  end

  assign {right_rise, left_rise, pause_rise, start_rise} = det_rise;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    lp, lp_nxt, rp, rp_nxt;
  logic [1:0]    win, win_nxt;
  logic          start_nxt, brst_nxt;
  logic          animate_q, start_q, brst_q;

  // next-state, counters and pulse requests
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lp_nxt    = lp;
    rp_nxt    = rp;
    win_nxt   = win;
    start_nxt = 1'b0;
    brst_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          brst_nxt  = 1'b1;
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // counter clears on the stb that reaches the delay, so it never wraps
        if (in_ani_stb) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            start_nxt = 1'b1;
            state_nxt = ST_PLAY;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_PLAY, ST_PAUSED: begin
        // score beats pause; left beats right
        if (left_rise) begin
          lp_nxt = lp + 1'b1;
          if (lp_nxt == WIN_PTS) begin
            win_nxt   = WIN_LEFT;
            state_nxt = ST_OVER;
          end else begin
            state_nxt = ST_SERVE;
          end
        end else if (right_rise) begin
          rp_nxt = rp + 1'b1;
          if (rp_nxt == WIN_PTS) begin
            win_nxt   = WIN_RIGHT;
            state_nxt = ST_OVER;
          end else begin
            state_nxt = ST_SERVE;
          end
        end else if (pause_rise) begin
          state_nxt = (state == ST_PLAY) ? ST_PAUSED : ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          lp_nxt    = '0;
          rp_nxt    = '0;
          win_nxt   = WIN_NONE;
          brst_nxt  = 1'b1;
          state_nxt = ST_SERVE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state and output registers; animate tracks the registered state
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lp        <= '0;
      rp        <= '0;
      win       <= WIN_NONE;
      animate_q <= 1'b0;
      start_q   <= 1'b0;
      brst_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lp        <= lp_nxt;
      rp        <= rp_nxt;
      win       <= win_nxt;
      animate_q <= (state_nxt == ST_PLAY);
      start_q   <= start_nxt;
      brst_q    <= brst_nxt;
    end
  end

  assign ball.animate     = animate_q;
  assign ball.start       = start_q;
  assign ball.ball_reset  = brst_q;
  assign out_left_points  = lp;
  assign out_right_points = rp;
  assign out_winner       = win;
  assign out_state        = state;
endmodule
